// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared types and constants for the shift sequencer
//   state_t      controller state (IDLE, RUN, DONE)
//   MODE_*       shifter Mode codes; 110/111 are reserved and passed through
//   *_DEF        default widths for operand, Mode and step count
package shift_seq_pkg;
    localparam int WIDTH_DEF  = 4;
    localparam int MODE_W_DEF = 3;
    localparam int CNT_W_DEF  = 3;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_SAR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
endpackage

// File: rtl/shift_sequencer_rr_arb2.sv
// rr_arb2: two-way round-robin grant
//   req_valid   in  2  request bits
//   last_grant  in  1  requester granted most recently
//   grant       out 2  one-hot grant (or 00 when nothing is requested)
module rr_arb2 (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic [1:0] grant
);
    // On a tie the requester that was not served last wins.
    assign grant = (&req_valid) ? (last_grant ? 2'b01 : 2'b10) : req_valid;
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-step controller for an external single-step shifter
//   req_valid/req_ready     per-requester request handshake (2 requesters)
//   req_data*/mode*/cnt*    operand, shifter Mode, step count per requester
//   sh_a/sh_mode/sh_r       connection to the combinational shifter
//   resp_valid/resp_ready   response handshake; resp_data/resp_id hold the result
//   busy                    high while a request is running or awaiting pickup
import shift_seq_pkg::*;

module shift_sequencer #(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int MODE_W = MODE_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [WIDTH-1:0]  req_data0,
    input  logic [MODE_W-1:0] req_mode0,
    input  logic [CNT_W-1:0]  req_cnt0,
    input  logic [WIDTH-1:0]  req_data1,
    input  logic [MODE_W-1:0] req_mode1,
    input  logic [CNT_W-1:0]  req_cnt1,
    output logic [WIDTH-1:0]  sh_a,
    output logic [MODE_W-1:0] sh_mode,
    input  logic [WIDTH-1:0]  sh_r,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WIDTH-1:0]  resp_data,
    output logic              resp_id,
    output logic              busy
);
    state_t            state;
    logic              last_grant;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        grant;
    logic              sel;
    logic [WIDTH-1:0]  in_data;
    logic [MODE_W-1:0] in_mode;
    logic [CNT_W-1:0]  in_cnt;

    rr_arb2 u_arb (.req_valid(req_valid), .last_grant(last_grant), .grant(grant));

    assign req_ready = (state == IDLE) ? grant : 2'b00;
    assign sel       = req_ready[1];
    assign in_data   = sel ? req_data1 : req_data0;
    assign in_mode   = sel ? req_mode1 : req_mode0;
    assign in_cnt    = sel ? req_cnt1  : req_cnt0;

    // sh_a doubles as the working register; sh_mode carries the Mode only in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
            sh_a       <= '0;
            sh_mode    <= MODE_W'(MODE_HOLD);
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req_ready) begin
                    sh_a       <= in_data;
                    cnt        <= in_cnt;
                    resp_id    <= sel;
                    last_grant <= sel;
                    busy       <= 1'b1;
                    if (in_cnt != '0) begin
                        state   <= RUN;
                        sh_mode <= in_mode;
                    end else begin
                        state      <= DONE;
                        resp_data  <= in_data;
                        resp_valid <= 1'b1;
                    end
                end
                RUN: begin
                    sh_a <= sh_r;
                    cnt  <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state      <= DONE;
                        resp_data  <= sh_r;
                        resp_valid <= 1'b1;
                        sh_mode    <= MODE_W'(MODE_HOLD);
                    end
                end
                DONE: if (resp_ready) begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed, table-driven check of shift_sequencer with a behavioural shifter
import shift_seq_pkg::*;

module tb_shift_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid, req_ready;
    logic [3:0] req_data0, req_data1, sh_a, sh_r, resp_data;
    logic [2:0] req_mode0, req_mode1, sh_mode, req_cnt0, req_cnt1;
    logic       resp_valid, resp_ready, resp_id, busy;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    shift_sequencer dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_data0(req_data0), .req_mode0(req_mode0), .req_cnt0(req_cnt0),
        .req_data1(req_data1), .req_mode1(req_mode1), .req_cnt1(req_cnt1),
        .sh_a(sh_a), .sh_mode(sh_mode), .sh_r(sh_r),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id), .busy(busy)
    );

    function automatic logic [3:0] shifter(input logic [3:0] a, input logic [2:0] m);
        case (m)
            MODE_SHL: return {a[2:0], 1'b0};
            MODE_SHR: return {1'b0, a[3:1]};
            MODE_SAR: return {a[3], a[3:1]};
            MODE_ROL: return {a[2:0], a[3]};
            MODE_ROR: return {a[0], a[3:1]};
            default:  return a;
        endcase
    endfunction

    assign sh_r = shifter(sh_a, sh_mode);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic ack();
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("ack_valid_low", resp_valid, 0);
        chk("ack_busy_low", busy, 0);
    endtask

    task automatic run_txn(input int id, input logic [3:0] d, input logic [2:0] m,
                           input logic [2:0] c, input logic [3:0] exp);
        int lat;
        @(negedge clk);
        if (id == 1) begin
            req_data1 = d; req_mode1 = m; req_cnt1 = c; req_valid = 2'b10;
        end else begin
            req_data0 = d; req_mode0 = m; req_cnt0 = c; req_valid = 2'b01;
        end
        #1 chk("txn_ready", req_ready, id == 1 ? 2 : 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        chk("txn_sh_mode", sh_mode, c != 0 ? int'(m) : 0);
        chk("txn_sh_a", sh_a, d);
        wait_resp(lat);
        chk("txn_latency", lat, int'(c) + 1);
        chk("txn_data", resp_data, exp);
        chk("txn_id", resp_id, id);
        chk("txn_busy", busy, 1);
        ack();
    endtask

    typedef struct {
        int         id;
        logic [3:0] d;
        logic [2:0] m;
        logic [2:0] c;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[7];
    logic [1:0] exp_grant[4];

    initial begin
        int lat, n;
        logic [3:0] held;
        vecs[0] = '{0, 4'b0101, MODE_SHL, 3'd1, 4'b1010};
        vecs[1] = '{1, 4'b0011, MODE_ROL, 3'd3, 4'b1001};
        vecs[2] = '{0, 4'b1000, MODE_SAR, 3'd2, 4'b1110};
        vecs[3] = '{1, 4'b0110, MODE_SHL, 3'd0, 4'b0110};
        vecs[4] = '{0, 4'b1011, 3'b110,   3'd2, 4'b1011};
        vecs[5] = '{1, 4'b1001, MODE_ROR, 3'd7, 4'b0011};
        vecs[6] = '{0, 4'b0111, MODE_SHR, 3'd1, 4'b0011};
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b10;
        exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;

        rst = 1'b1; req_valid = 2'b00; resp_ready = 1'b0;
        req_data0 = '0; req_mode0 = '0; req_cnt0 = '0;
        req_data1 = '0; req_mode1 = '0; req_cnt1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_sh_a", sh_a, 0);
        chk("rst_sh_mode", sh_mode, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        rst = 1'b0;

        // Tie right after reset: requester 0 first, then requester 1.
        req_data0 = 4'b0101; req_mode0 = MODE_SHR; req_cnt0 = 3'd1;
        req_data1 = 4'b1100; req_mode1 = MODE_ROR; req_cnt1 = 3'd2;
        req_valid = 2'b11;
        #1 chk("tie_first_grant", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b10;
        wait_resp(lat);
        chk("tie_r0_latency", lat, 2);
        chk("tie_r0_data", resp_data, 4'b0010);
        chk("tie_r0_id", resp_id, 0);
        chk("tie_done_ready", req_ready, 0);
        ack();
        #1 chk("tie_second_grant", req_ready, 2);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        wait_resp(lat);
        chk("tie_r1_latency", lat, 3);
        chk("tie_r1_data", resp_data, 4'b0011);
        chk("tie_r1_id", resp_id, 1);
        ack();

        // Both held valid: grants alternate starting from requester 0.
        req_cnt0 = 3'd0; req_cnt1 = 3'd0; req_valid = 2'b11; resp_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            #1;
            if (req_ready != 2'b00) begin
                chk("alt_grant", req_ready, exp_grant[n]);
                n++;
            end
            @(negedge clk);
        end
        chk("alt_count", n, 4);
        req_valid = 2'b00; resp_ready = 1'b0;
        ack();

        for (int i = 0; i < 7; i++)
            run_txn(vecs[i].id, vecs[i].d, vecs[i].m, vecs[i].c, vecs[i].exp);

        // Response back-pressure: output held, new requests blocked.
        @(negedge clk);
        req_data0 = 4'b0101; req_mode0 = MODE_SHL; req_cnt0 = 3'd2; req_valid = 2'b01;
        @(posedge clk);
        @(negedge clk);
        wait_resp(lat);
        chk("bp_latency", lat, 3);
        held = resp_data;
        chk("bp_data", held, 4'b0100);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", resp_valid, 1);
            chk("bp_hold_data", resp_data, 4'b0100);
            chk("bp_hold_id", resp_id, 0);
            chk("bp_hold_ready", req_ready, 0);
            chk("bp_hold_busy", busy, 1);
        end
        req_valid = 2'b00;
        ack();

        // Reset in the middle of a long run.
        @(negedge clk);
        req_data1 = 4'b1010; req_mode1 = MODE_ROL; req_cnt1 = 3'd5; req_valid = 2'b10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_sh_a", sh_a, 0);
        chk("mid_rst_sh_mode", sh_mode, 0);
        chk("mid_rst_valid", resp_valid, 0);
        chk("mid_rst_data", resp_data, 0);
        chk("mid_rst_id", resp_id, 0);
        chk("mid_rst_busy", busy, 0);
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid) n++;
        end
        chk("mid_rst_no_resp", n, 0);
        req_data0 = 4'b0001; req_cnt0 = 3'd0; req_valid = 2'b11;
        #1 chk("mid_rst_tie_grant", req_ready, 1);
        req_valid = 2'b00;
        run_txn(1, 4'b1010, MODE_ROL, 3'd1, 4'b0101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
